// File: rtl/follower_pkg.sv
// Shared types and constants for the command scheduler between UART_wrapper and cmd_proc.
package follower_pkg;

    typedef enum logic {RUN, ABORT} sched_state_t;

    localparam logic [15:0] ABORT_CMD_DEF   = 16'h0000;
    localparam int          ABORT_HOLD_FAST = 256;
    localparam int          ABORT_HOLD_SLOW = 1 << 22;

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH x W synchronous FIFO with combinational head read and a flush that overrides push/pop.
module cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_sched.sv
// Queues UART commands for cmd_proc; an abort code flushes the queue and blocks ingress for a fixed hold.
module cmd_sched
    import follower_pkg::*;
#(
    parameter  int          DEPTH     = 4,
    parameter  logic [15:0] ABORT_CMD = ABORT_CMD_DEF,
    parameter  bit          FAST_SIM  = 1'b1,
    localparam int          CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   u_cmd,
    input  logic          u_cmd_rdy,
    output logic          u_clr_cmd_rdy,
    output logic [15:0]   p_cmd,
    output logic          p_cmd_rdy,
    input  logic          p_clr_cmd_rdy,
    output logic          abort,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovfl
);

    localparam int HOLD = FAST_SIM ? ABORT_HOLD_FAST : ABORT_HOLD_SLOW;
    localparam int TW   = $clog2(HOLD);

    sched_state_t state;
    logic [TW-1:0] timer;
    logic          empty;
    logic          in_run;
    logic          is_abort;
    logic          abort_hit;
    logic          push;
    logic          pop;
    logic          ovfl_hit;

    // Abort beats push and pop; a full queue blocks ingress even if a pop happens this cycle.
    assign in_run        = (state == RUN);
    assign is_abort      = u_cmd_rdy && (u_cmd == ABORT_CMD);
    assign abort_hit     = in_run && is_abort;
    assign push          = in_run && u_cmd_rdy && !is_abort && !full;
    assign pop           = in_run && p_clr_cmd_rdy && !empty && !abort_hit;
    assign ovfl_hit      = in_run && u_cmd_rdy && !is_abort && full;
    assign u_clr_cmd_rdy = abort_hit || push;
    assign p_cmd_rdy     = in_run && !empty;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (abort_hit),
        .wdata (u_cmd),
        .rdata (p_cmd),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            timer <= '0;
            abort <= 1'b0;
            ovfl  <= 1'b0;
        end else begin
            if (ovfl_hit) ovfl <= 1'b1;
            case (state)
                RUN: begin
                    if (abort_hit) begin
                        state <= ABORT;
                        abort <= 1'b1;
                        timer <= '0;
                    end
                end
                ABORT: begin
                    timer <= timer + TW'(1);
                    if (timer == TW'(HOLD - 1)) begin
                        state <= RUN;
                        abort <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    abort <= 1'b0;
                end
            endcase
        end
    end

endmodule
